// File: rtl/musicbox_memory_arbiter_if.sv
// Bundle of requester and memory-side signals of the MusicBox memory arbiter.
// slave = arbiter side, master = requesters plus memory (the environment).
interface musicbox_memory_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              rec_request;
  logic [ADDR_W-1:0] rec_address;
  logic [DATA_W-1:0] rec_writeData;
  logic              rec_done;
  logic              play_request;
  logic [ADDR_W-1:0] play_address;
  logic              play_done;
  logic              song_request;
  logic [ADDR_W-1:0] song_address;
  logic              song_done;
  logic [DATA_W-1:0] readData;
  logic [2:0]        grant;
  logic              busy;
  logic              timeoutError;
  logic              mem_request;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writeData;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_readData;

  // Handshake: a requester holds request/address/data stable until its done
  // pulse; the memory answers each one-cycle mem_request with one mem_ready.
  modport slave (
    input  rec_request, rec_address, rec_writeData,
    input  play_request, play_address,
    input  song_request, song_address,
    input  mem_ready, mem_readData,
    output rec_done, play_done, song_done,
    output readData, grant, busy, timeoutError,
    output mem_request, mem_write, mem_address, mem_writeData
  );

  modport master (
    output rec_request, rec_address, rec_writeData,
    output play_request, play_address,
    output song_request, song_address,
    output mem_ready, mem_readData,
    input  rec_done, play_done, song_done,
    input  readData, grant, busy, timeoutError,
    input  mem_request, mem_write, mem_address, mem_writeData
  );
endinterface

// File: rtl/musicbox_memory_arbiter.sv
// Round-robin arbiter sharing one single-port sample memory between the
// record writer, playback reader and song reader, with per-transaction timeout.
module musicbox_memory_arbiter #(
  parameter int         ADDR_W         = 16,
  parameter int         DATA_W         = 16,
  parameter logic [4:0] STATE_RECORD   = 5'd3,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic        clock_50Mhz,
  input  logic        reset,
  input  logic [4:0]  currentState,
  output logic [1:0]  debugState,
  musicbox_memory_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} arbState_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  arbState_t         state, nextState;
  logic [2:0]        eligible, winner, grantReg, lastGrant;
  logic [ADDR_W-1:0] addressReg;
  logic [DATA_W-1:0] writeDataReg, readDataReg;
  logic              writeReg, timeoutArmed;
  logic [CNT_W-1:0]  waitCount;

  assign eligible = {bus.song_request, bus.play_request,
                     bus.rec_request && (currentState == STATE_RECORD)};

  // Search starts just after the last owner: rec -> play -> song -> rec.
  always_comb begin
    winner = 3'b000;
    case (lastGrant)
      3'b001: begin
        if      (eligible[1]) winner = 3'b010;
        else if (eligible[2]) winner = 3'b100;
        else if (eligible[0]) winner = 3'b001;
      end
      3'b010: begin
        if      (eligible[2]) winner = 3'b100;
        else if (eligible[0]) winner = 3'b001;
        else if (eligible[1]) winner = 3'b010;
      end
      default: begin
        if      (eligible[0]) winner = 3'b001;
        else if (eligible[1]) winner = 3'b010;
        else if (eligible[2]) winner = 3'b100;
      end
    endcase
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (|eligible) nextState = ISSUE;
      ISSUE:   nextState = WAIT;
      WAIT:    if (bus.mem_ready || (waitCount == LAST_WAIT)) nextState = RESPOND;
      RESPOND: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      state        <= IDLE;
      grantReg     <= 3'b000;
      lastGrant    <= 3'b100;
      addressReg   <= '0;
      writeDataReg <= '0;
      readDataReg  <= '0;
      writeReg     <= 1'b0;
      timeoutArmed <= 1'b0;
      waitCount    <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (|eligible) begin
            grantReg     <= winner;
            writeReg     <= winner[0];
            writeDataReg <= bus.rec_writeData;
            if (winner[0])      addressReg <= bus.rec_address;
            else if (winner[1]) addressReg <= bus.play_address;
            else                addressReg <= bus.song_address;
          end
        end
        ISSUE: begin
          waitCount    <= '0;
          timeoutArmed <= 1'b0;
        end
        WAIT: begin
          // A real answer wins over a timeout landing in the same cycle.
          if (bus.mem_ready) begin
            if (!writeReg) readDataReg <= bus.mem_readData;
          end else if (waitCount == LAST_WAIT) begin
            readDataReg  <= '0;
            timeoutArmed <= 1'b1;
          end else begin
            waitCount <= waitCount + 1'b1;
          end
        end
        RESPOND: begin
          lastGrant    <= grantReg;
          grantReg     <= 3'b000;
          writeReg     <= 1'b0;
          timeoutArmed <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign debugState        = state;
  assign bus.busy          = (state != IDLE);
  assign bus.grant         = grantReg;
  assign bus.mem_request   = (state == ISSUE);
  assign bus.mem_write     = writeReg;
  assign bus.mem_address   = addressReg;
  assign bus.mem_writeData = writeDataReg;
  assign bus.readData      = readDataReg;
  assign bus.rec_done      = (state == RESPOND) && grantReg[0];
  assign bus.play_done     = (state == RESPOND) && grantReg[1];
  assign bus.song_done     = (state == RESPOND) && grantReg[2];
  assign bus.timeoutError  = (state == RESPOND) && timeoutArmed;

endmodule

// File: tb/tb_musicbox_memory_arbiter.sv
// Directed bench for musicbox_memory_arbiter: one task per scenario, with a
// small latency-programmable memory responder.
module tb_musicbox_memory_arbiter;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 64;

  logic       clock_50Mhz = 1'b0;
  logic       reset;
  logic [4:0] currentState;
  logic [1:0] debugState;

  musicbox_memory_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  musicbox_memory_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STATE_RECORD(5'd3), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock_50Mhz (clock_50Mhz),
    .reset       (reset),
    .currentState(currentState),
    .debugState  (debugState),
    .bus         (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];

  // memory responder: answers mem_request after memLatency cycles
  bit                memEnable = 1'b1;
  bit                memSilent = 1'b0;
  int                memLatency = 1;
  int                pending = -1;
  logic [DATA_W-1:0] memReadValue = '0;
  logic              respReady = 1'b0;
  logic [DATA_W-1:0] respData = '0;
  logic              manualReady = 1'b0;
  logic [DATA_W-1:0] manualData = '0;

  assign bus.mem_ready    = memEnable ? respReady : manualReady;
  assign bus.mem_readData = memEnable ? respData  : manualData;

  always #10 clock_50Mhz = ~clock_50Mhz;

  always begin
    @(posedge clock_50Mhz); #2;
    respReady = 1'b0;
    if (!memEnable) begin
      pending = -1;
    end else begin
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          respReady = 1'b1;
          respData  = memReadValue;
          pending   = -1;
        end
      end
      if (bus.mem_request && !memSilent) pending = memLatency;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock_50Mhz); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.grant !== 3'b000) begin bad++; $display("FAIL reset_grant: got %b want 000", bus.grant); end
    total++; if (bus.mem_request !== 1'b0 || bus.mem_write !== 1'b0) begin bad++; $display("FAIL reset_mem_ctrl: got req=%b wr=%b want 0 0", bus.mem_request, bus.mem_write); end
    total++; if (bus.mem_address !== 16'h0 || bus.mem_writeData !== 16'h0 || bus.readData !== 16'h0) begin bad++; $display("FAIL reset_data: got addr=%h wd=%h rd=%h want 0", bus.mem_address, bus.mem_writeData, bus.readData); end
    total++; if ({bus.song_done, bus.play_done, bus.rec_done, bus.timeoutError} !== 4'b0) begin bad++; $display("FAIL reset_done: got %b want 0000", {bus.song_done, bus.play_done, bus.rec_done, bus.timeoutError}); end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    currentState = 5'd1;
    memLatency = 2; memReadValue = 16'hBEEF;
    bus.play_address = 16'h0010; bus.play_request = 1'b1;
    tick();  // cycle 1
    total++; if (bus.mem_request !== 1'b1 || bus.mem_write !== 1'b0) begin bad++; $display("FAIL read_issue: got req=%b wr=%b want 1 0", bus.mem_request, bus.mem_write); end
    total++; if (bus.mem_address !== 16'h0010) begin bad++; $display("FAIL read_addr: got %h want 0010", bus.mem_address); end
    total++; if (bus.grant !== 3'b010) begin bad++; $display("FAIL read_grant: got %b want 010", bus.grant); end
    tick(); tick();
    total++; if (bus.play_done !== 1'b0) begin bad++; $display("FAIL read_early_done: got %b want 0", bus.play_done); end
    tick();  // cycle 4
    total++; if (bus.play_done !== 1'b1 || bus.readData !== 16'hBEEF) begin bad++; $display("FAIL read_done: got done=%b data=%h want 1 beef", bus.play_done, bus.readData); end
    bus.play_request = 1'b0;
    tick();
    total++; if (bus.grant !== 3'b000 || bus.busy !== 1'b0 || bus.play_done !== 1'b0) begin bad++; $display("FAIL read_idle: got grant=%b busy=%b done=%b want 000 0 0", bus.grant, bus.busy, bus.play_done); end
  endtask

  task automatic test_record_gating();
    int issued;
    currentState = 5'd1;
    memLatency = 1; memReadValue = 16'h1111;
    bus.rec_address = 16'h1234; bus.rec_writeData = 16'hA5A5; bus.rec_request = 1'b1;
    issued = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.mem_request || bus.busy) issued++;
    end
    total++; if (issued !== 0) begin bad++; $display("FAIL rec_gated: got %0d active cycles want 0", issued); end
    currentState = 5'd3;
    tick();
    total++; if (bus.mem_request !== 1'b1 || bus.mem_write !== 1'b1) begin bad++; $display("FAIL rec_issue: got req=%b wr=%b want 1 1", bus.mem_request, bus.mem_write); end
    total++; if (bus.mem_address !== 16'h1234 || bus.mem_writeData !== 16'hA5A5) begin bad++; $display("FAIL rec_bus: got addr=%h data=%h want 1234 a5a5", bus.mem_address, bus.mem_writeData); end
    currentState = 5'd1;  // leaving record state must not abort the write
    tick(); tick();
    total++; if (bus.rec_done !== 1'b1 || bus.timeoutError !== 1'b0) begin bad++; $display("FAIL rec_done: got done=%b to=%b want 1 0", bus.rec_done, bus.timeoutError); end
    total++; if (bus.readData !== 16'hBEEF) begin bad++; $display("FAIL rec_readdata_kept: got %h want beef", bus.readData); end
    bus.rec_request = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    int cyc, got;
    logic [2:0] doneVec, expGrant;
    reset = 1'b1; tick(); reset = 1'b0;
    exp_q = {};
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(3'b001); exp_q.push_back(3'b010); exp_q.push_back(3'b100);
    end
    currentState = 5'd3; memLatency = 1; memReadValue = 16'h5A5A;
    bus.rec_address = 16'h0100; bus.play_address = 16'h0200; bus.song_address = 16'h0300;
    bus.rec_request = 1'b1; bus.play_request = 1'b1; bus.song_request = 1'b1;
    cyc = 0; got = 0;
    while (got < 6 && cyc < 60) begin
      tick(); cyc++;
      doneVec = {bus.song_done, bus.play_done, bus.rec_done};
      if (doneVec != 3'b000) begin
        expGrant = exp_q.pop_front();
        total++; if (doneVec !== expGrant) begin bad++; $display("FAIL rr_order[%0d]: got %b want %b", got, doneVec, expGrant); end
        total++; if (cyc !== 3 + 4 * got) begin bad++; $display("FAIL rr_timing[%0d]: got cycle %0d want %0d", got, cyc, 3 + 4 * got); end
        got++;
      end
    end
    total++; if (got !== 6) begin bad++; $display("FAIL rr_count: got %0d want 6", got); end
    bus.rec_request = 1'b0; bus.play_request = 1'b0; bus.song_request = 1'b0;
    currentState = 5'd1;
    tick(); tick();
  endtask

  task automatic test_timeout();
    int cnt;
    memSilent = 1'b1;
    bus.song_address = 16'h0300; bus.song_request = 1'b1;
    tick();
    total++; if (bus.mem_request !== 1'b1 || bus.mem_address !== 16'h0300) begin bad++; $display("FAIL to_issue: got req=%b addr=%h want 1 0300", bus.mem_request, bus.mem_address); end
    cnt = 0;
    while (bus.song_done !== 1'b1 && cnt < 200) begin tick(); cnt++; end
    total++; if (cnt !== TIMEOUT + 1) begin bad++; $display("FAIL to_latency: got %0d want %0d", cnt, TIMEOUT + 1); end
    total++; if (bus.timeoutError !== 1'b1 || bus.readData !== 16'h0) begin bad++; $display("FAIL to_flags: got to=%b data=%h want 1 0000", bus.timeoutError, bus.readData); end
    bus.song_request = 1'b0; memSilent = 1'b0;
    tick();
    total++; if (bus.timeoutError !== 1'b0 || bus.song_done !== 1'b0) begin bad++; $display("FAIL to_pulse: got to=%b done=%b want 0 0", bus.timeoutError, bus.song_done); end
    memLatency = 2; memReadValue = 16'h1357;
    bus.play_address = 16'h0044; bus.play_request = 1'b1;
    cnt = 0;
    while (bus.play_done !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    total++; if (cnt !== 4 || bus.readData !== 16'h1357 || bus.timeoutError !== 1'b0) begin bad++; $display("FAIL to_recover: got cyc=%0d data=%h to=%b want 4 1357 0", cnt, bus.readData, bus.timeoutError); end
    bus.play_request = 1'b0;
    tick();
  endtask

  task automatic test_stray_ready();
    int cnt;
    memLatency = 1; memReadValue = 16'h2468;
    bus.play_address = 16'h0050; bus.play_request = 1'b1;
    cnt = 0;
    while (bus.play_done !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    total++; if (bus.readData !== 16'h2468) begin bad++; $display("FAIL stray_setup: got %h want 2468", bus.readData); end
    bus.play_request = 1'b0;
    tick();
    memEnable = 1'b0; manualReady = 1'b1; manualData = 16'hFFFF;
    tick();
    total++; if (bus.busy !== 1'b0 || bus.readData !== 16'h2468 || bus.play_done !== 1'b0) begin bad++; $display("FAIL stray_idle: got busy=%b data=%h done=%b want 0 2468 0", bus.busy, bus.readData, bus.play_done); end
    manualReady = 1'b0;
    bus.play_request = 1'b1;
    tick();  // ISSUE
    manualReady = 1'b1;
    tick();  // WAIT, stray ready seen in ISSUE must be dropped
    manualReady = 1'b0;
    tick();
    total++; if (bus.play_done !== 1'b0 || debugState !== 2'd2 || bus.readData !== 16'h2468) begin bad++; $display("FAIL stray_issue: got done=%b st=%0d data=%h want 0 2 2468", bus.play_done, debugState, bus.readData); end
    manualReady = 1'b1; manualData = 16'h7777;
    tick();
    manualReady = 1'b0;
    total++; if (bus.play_done !== 1'b1 || bus.readData !== 16'h7777) begin bad++; $display("FAIL stray_real: got done=%b data=%h want 1 7777", bus.play_done, bus.readData); end
    bus.play_request = 1'b0;
    tick();
    memEnable = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    int doneSeen;
    memSilent = 1'b1;
    bus.play_address = 16'h0060; bus.play_request = 1'b1;
    tick(); tick(); tick();
    total++; if (debugState !== 2'd2 || bus.busy !== 1'b1) begin bad++; $display("FAIL rst_wait_setup: got st=%0d busy=%b want 2 1", debugState, bus.busy); end
    reset = 1'b1; bus.play_request = 1'b0;
    tick();
    reset = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.grant !== 3'b000 || bus.play_done !== 1'b0) begin bad++; $display("FAIL rst_wait: got busy=%b grant=%b done=%b want 0 000 0", bus.busy, bus.grant, bus.play_done); end
    memSilent = 1'b0; memEnable = 1'b0; manualReady = 1'b1; manualData = 16'hDEAD;
    tick();
    manualReady = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.play_done || bus.rec_done || bus.song_done || bus.busy) doneSeen++;
      tick();
    end
    total++; if (doneSeen !== 0 || bus.readData !== 16'h0) begin bad++; $display("FAIL rst_late_ready: got activity=%0d data=%h want 0 0000", doneSeen, bus.readData); end
    memEnable = 1'b1;
  endtask

  initial begin
    reset = 1'b1; currentState = 5'd0;
    bus.rec_request = 1'b0; bus.rec_address = '0; bus.rec_writeData = '0;
    bus.play_request = 1'b0; bus.play_address = '0;
    bus.song_request = 1'b0; bus.song_address = '0;
    test_reset();
    test_single_read();
    test_record_gating();
    test_round_robin();
    test_timeout();
    test_stray_ready();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
